// File: rtl/uart_flash_loader_pkg.sv
// uart_flash_loader_pkg: loader state encoding and frame command bytes.
package uart_flash_loader_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, WRITE, RUN} state_t;
  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_BOOT  = 8'h5A;
endpackage

// File: rtl/uart_flash_loader.sv
// uart_flash_loader: assembles checksummed UART write frames into flash word writes, then releases the core on boot.
module uart_flash_loader
  import uart_flash_loader_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             flash_en,
  output logic             cpu_hold,
  output logic             err,
  output logic [15:0]      word_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [WIDTH-1:0] addr_q, addr_d, data_q, data_d;
  logic [WIDTH-1:0] flash_addr_q, flash_addr_d, flash_data_q, flash_data_d;
  logic [7:0] csum_q, csum_d;
  logic rx_ready_q, rx_ready_d, flash_en_q, flash_en_d, err_q, err_d;
  logic [15:0] word_count_q, word_count_d;
  logic acc, in_frame;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    csum_d = csum_q;
    flash_addr_d = flash_addr_q;
    flash_data_d = flash_data_q;
    word_count_d = word_count_q;
    flash_en_d = 1'b0;
    err_d = 1'b0;
    acc = rx_valid && rx_ready_q;
    in_frame = state_q == ADDR || state_q == DATA || state_q == CSUM;
    to_d = (in_frame && !acc) ? to_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (acc) begin
        state_d = rx_data == CMD_WRITE ? ADDR : rx_data == CMD_BOOT ? RUN : IDLE;
        cnt_d = 2'd0;
        csum_d = 8'd0;
      end
      ADDR: if (acc) begin
        addr_d = {rx_data, addr_q[WIDTH-1:8]};
        csum_d = csum_q ^ rx_data;
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? DATA : ADDR;
      end
      DATA: if (acc) begin
        data_d = {rx_data, data_q[WIDTH-1:8]};
        csum_d = csum_q ^ rx_data;
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? CSUM : DATA;
      end
      CSUM: if (acc) begin
        if (rx_data == csum_q && addr_q[1:0] == 2'b00) begin
          state_d = WRITE;
          flash_en_d = 1'b1;
          flash_addr_d = addr_q;
          flash_data_d = data_q;
          word_count_d = word_count_q + 16'd1;
        end else begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = RUN;
    endcase
    // an idle gap of TIMEOUT cycles inside a frame abandons it
    if (in_frame && !acc && to_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      err_d = 1'b1;
      to_d = '0;
    end
    rx_ready_d = state_d != WRITE && state_d != RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      to_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      csum_q <= '0;
      flash_addr_q <= '0;
      flash_data_q <= '0;
      word_count_q <= '0;
      flash_en_q <= 1'b0;
      err_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      addr_q <= addr_d;
      data_q <= data_d;
      csum_q <= csum_d;
      flash_addr_q <= flash_addr_d;
      flash_data_q <= flash_data_d;
      word_count_q <= word_count_d;
      flash_en_q <= flash_en_d;
      err_q <= err_d;
      rx_ready_q <= rx_ready_d;
    end
  end
  assign rx_ready = rx_ready_q;
  assign flash_addr = flash_addr_q;
  assign flash_data = flash_data_q;
  assign flash_en = flash_en_q;
  assign err = err_q;
  assign word_count = word_count_q;
  assign cpu_hold = state_q != RUN;
endmodule

// File: tb/tb_uart_flash_loader.sv
// tb_uart_flash_loader: directed and randomized frames checked against a frame-level reference model.
module tb_uart_flash_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_valid = 1'b0;
  logic rx_ready, flash_en, cpu_hold, err;
  logic [31:0] flash_addr, flash_data;
  logic [15:0] word_count;
  int compared = 0;
  int mismatched = 0;
  int flash_pulses = 0;
  int err_pulses = 0;
  int exp_writes = 0;
  int exp_errs = 0;
  logic [15:0] exp_wc = 16'd0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_data = 32'd0;

  uart_flash_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .flash_addr(flash_addr), .flash_data(flash_data), .flash_en(flash_en),
    .cpu_hold(cpu_hold), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (flash_en) flash_pulses++;
    if (err) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Sends a write frame; returns one step after the checksum byte's accepting edge.
  task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input logic [7:0] cs, input int maxgap);
    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], $urandom_range(maxgap));
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], $urandom_range(maxgap));
    send_byte(cs, $urandom_range(maxgap));
  endtask

  function automatic logic [7:0] xsum(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 4; i++) s = s ^ a[8*i +: 8] ^ d[8*i +: 8];
    return s;
  endfunction

  // Checks the cycle after the checksum byte and the following cycle against the model.
  task automatic frame_check(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [7:0] cs);
    logic good;
    good = cs == xsum(a, d) && a[1:0] == 2'b00;
    if (good) begin
      exp_wc = exp_wc + 16'd1;
      exp_addr = a;
      exp_data = d;
      exp_writes++;
    end else exp_errs++;
    chk({tag, ".flash_en"}, {31'd0, flash_en}, {31'd0, good});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, !good});
    chk({tag, ".rx_ready"}, {31'd0, rx_ready}, {31'd0, !good});
    chk({tag, ".addr"}, flash_addr, exp_addr);
    chk({tag, ".data"}, flash_data, exp_data);
    chk({tag, ".wc"}, {16'd0, word_count}, {16'd0, exp_wc});
    @(posedge clk);
    #1;
    chk({tag, ".idle_after"}, {29'd0, flash_en, err, rx_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [7:0] cs;
    #1;
    chk("rst.rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst.outs", {29'd0, flash_en, err, rx_ready}, 32'd0);
    chk("rst.wc", {16'd0, word_count}, 32'd0);
    chk("rst.addr", flash_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("post_rst.rx_ready", {31'd0, rx_ready}, 32'd1);

    send_frame(32'h24, 32'h5, 8'h21, 0);
    frame_check("good", 32'h24, 32'h5, 8'h21);
    send_frame(32'h24, 32'h5, 8'h22, 0);
    frame_check("bad_csum", 32'h24, 32'h5, 8'h22);
    send_frame(32'h25, 32'h5, xsum(32'h25, 32'h5), 0);
    frame_check("misalign", 32'h25, 32'h5, xsum(32'h25, 32'h5));

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      d = $urandom;
      a[1:0] = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cs = xsum(a, d) ^ (($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      if ($urandom_range(1) == 1) send_byte(8'h33, 0);
      send_frame(a, d, cs, 3);
      frame_check("rand", a, d, cs);
    end

    send_byte(8'hA5, 0);
    send_byte(8'h24, 0);
    send_byte(8'h00, 0);
    repeat (1023) @(posedge clk);
    #1;
    chk("to.before", {30'd0, err, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("to.err", {30'd0, err, flash_en}, 32'd2);
    exp_errs++;
    @(posedge clk);
    #1 chk("to.err_clear", {31'd0, err}, 32'd0);
    send_frame(32'h100, 32'hCAFEF00D, xsum(32'h100, 32'hCAFEF00D), 0);
    frame_check("to.recover", 32'h100, 32'hCAFEF00D, xsum(32'h100, 32'hCAFEF00D));

    send_byte(8'hA5, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    exp_wc = 16'd0;
    exp_addr = 32'd0;
    exp_data = 32'd0;
    chk("midrst.outs", {29'd0, flash_en, err, rx_ready}, 32'd0);
    chk("midrst.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst.wc", {16'd0, word_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst.rx_ready", {31'd0, rx_ready}, 32'd1);
    send_frame(32'h24, 32'h5, 8'h21, 0);
    frame_check("midrst.next", 32'h24, 32'h5, 8'h21);

    send_byte(8'h33, 0);
    chk("boot.junk", {30'd0, cpu_hold, rx_ready}, 32'd3);
    send_byte(8'h5A, 0);
    chk("boot.run", {30'd0, cpu_hold, rx_ready}, 32'd0);
    send_frame(32'h40, 32'h1, xsum(32'h40, 32'h1), 0);
    @(posedge clk);
    #1;
    chk("boot.ignored", {14'd0, cpu_hold, rx_ready, word_count}, {16'd0, exp_wc});
    chk("pulses.flash", flash_pulses, exp_writes);
    chk("pulses.err", err_pulses, exp_errs);
    @(negedge clk) rst = 1'b0;
    #1 chk("boot.rst", {30'd0, cpu_hold, rx_ready}, 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_flash_loader.md
UART_FLASH_LOADER -- requirements
Module: uart_flash_loader

Interface
REQ-001 Parameter WIDTH, default 32: flash address/data width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 1024: maximum idle cycles allowed between bytes inside a frame.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 rx_data  in  8  received byte from the UART receiver.
REQ-006 rx_valid  in  1  rx_data is valid this cycle.
REQ-007 rx_ready  out  1  loader can accept a byte this cycle.
REQ-008 flash_addr  out  WIDTH  byte address of the instruction-memory write, driven to the top-level flash port.
REQ-009 flash_data  out  WIDTH  word to write.
REQ-010 flash_en  out  1  one-cycle write strobe; flash_addr and flash_data are valid while it is high.
REQ-011 cpu_hold  out  1  holds the core in reset while loading.
REQ-012 err  out  1  one-cycle pulse on any rejected frame.
REQ-013 word_count  out  16  number of words written since reset.

Function
REQ-014 A byte transfers only on a cycle where rx_valid and rx_ready are both high.
REQ-015 Frame format: command byte; 4 address bytes, little-endian; 4 data bytes, little-endian; 1 checksum byte.
REQ-016 The checksum is the XOR of the 8 address and data bytes.
REQ-017 Command 0xA5 = write word; command 0x5A = boot, a single-byte frame; any other command byte is discarded silently and the loader stays in IDLE.
REQ-018 States: IDLE, ADDR, DATA, CSUM, WRITE, RUN.
REQ-019 Transitions:
- IDLE to ADDR on 0xA5.
- IDLE to RUN on 0x5A.
- ADDR to DATA after the 4th address byte, tracked by a 2-bit byte counter.
- DATA to CSUM after the 4th data byte.
- CSUM to WRITE when the checksum matches and addr[1:0] == 0; otherwise CSUM to IDLE with err pulsed the next cycle.
- WRITE to IDLE after one cycle.
REQ-020 In WRITE, flash_en is high for exactly one cycle, flash_addr/flash_data hold the assembled values, and word_count increments by 1.
REQ-021 word_count wraps from 0xFFFF to 0x0000.
REQ-022 rx_ready is high in IDLE, ADDR, DATA and CSUM, and low in WRITE and RUN.
REQ-023 Latency: flash_en rises on the cycle after the checksum byte is accepted.
REQ-024 A timeout counter clears on every accepted byte and counts cycles spent in ADDR, DATA or CSUM.
REQ-025 When the timeout counter reaches TIMEOUT, the loader returns to IDLE, pulses err, discards the partial frame and does not assert flash_en.
REQ-026 cpu_hold is 1 in every state except RUN.
REQ-027 RUN is terminal until reset; all rx bytes are ignored in RUN.
REQ-028 flash_addr/flash_data keep their last written values outside WRITE; flash_en and err are 0 outside their pulse cycles.

Reset
REQ-029 While rst is low: state = IDLE; byte counter, timeout counter, assembly registers, flash_addr, flash_data, flash_en, err and word_count = 0; cpu_hold = 1; rx_ready = 0.
REQ-030 Reset asserted mid-frame discards the partial frame, with no flash_en and no err.
REQ-031 rx_ready = 1 from the first clock edge after rst deasserts.

Structure
REQ-032 The common package holds the loader state enum and the constants CMD_WRITE = 8'hA5 and CMD_BOOT = 8'h5A.
REQ-033 The block is a single module with no sub-modules; the UART receiver stays external.

Verification
REQ-034 Write frame A5 24 00 00 00 05 00 00 00 21 -> one flash_en pulse with flash_addr = 0x24 and flash_data = 0x00000005; word_count = 1.
REQ-035 Same frame with checksum 0x22 -> err pulses one cycle, no flash_en, word_count unchanged.
REQ-036 Address 0x25 with a correct checksum -> err pulses, no flash_en.
REQ-037 Frame A5 24 00, then 1024 idle cycles -> err pulses, loader returns to IDLE; a following valid frame writes correctly.
REQ-038 Byte 0x33 followed by 5A -> 0x33 is ignored; cpu_hold falls one cycle after 5A is accepted; later bytes are ignored and rx_ready = 0.
REQ-039 rst pulsed low after 6 frame bytes -> no flash_en, cpu_hold = 1, word_count = 0, loader in IDLE.
